// File: rtl/bus_read_arbiter.sv
// rtl/bus_read_arbiter.sv - round-robin read sequencer for two sources sharing one tri-stated data bus
module bus_read_arbiter #(
    parameter int DATA_W   = 8,
    parameter int READ_CYC = 1,
    parameter int GAP      = 1
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic [1:0]        req,
    input  logic [DATA_W-1:0] data,
    output logic [1:0]        read,
    output logic [DATA_W-1:0] sample,
    output logic              sample_src,
    output logic              sample_valid,
    output logic [DATA_W-1:0] last0,
    output logic [DATA_W-1:0] last1,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_INIT = 4'(READ_CYC - 1);
    localparam bit         GAP_EN    = (GAP > 0);
    localparam logic [3:0] GAP_INIT  = 4'(GAP_EN ? GAP - 1 : 0);

    state_t              state_q, state_d;
    logic [1:0]          read_q, read_d;
    logic [3:0]          hold_q, hold_d;
    logic [3:0]          gap_q, gap_d;
    logic                grant_q, grant_d;
    logic                rr_q, rr_d;
    logic [DATA_W-1:0]   sample_q, sample_d;
    logic                sample_src_q, sample_src_d;
    logic                sample_valid_q, sample_valid_d;
    logic [DATA_W-1:0]   last0_q, last0_d;
    logic [DATA_W-1:0]   last1_q, last1_d;
    logic                pick;

    // rr_q names the source that wins when both request; it always points away from the last grant
    always_comb begin
        state_d        = state_q;
        read_d         = read_q;
        hold_d         = hold_q;
        gap_d          = gap_q;
        grant_d        = grant_q;
        rr_d           = rr_q;
        sample_d       = sample_q;
        sample_src_d   = sample_src_q;
        sample_valid_d = 1'b0;
        last0_d        = last0_q;
        last1_d        = last1_q;
        pick           = (req == 2'b11) ? rr_q : req[1];

        case (state_q)
            ST_IDLE: begin
                read_d = 2'b00;
                if (|req) begin
                    grant_d = pick;
                    read_d  = pick ? 2'b10 : 2'b01;
                    hold_d  = HOLD_INIT;
                    rr_d    = ~pick;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                if (hold_q == 4'd0) begin
                    sample_d       = data;
                    sample_src_d   = grant_q;
                    sample_valid_d = 1'b1;
                    if (grant_q) last1_d = data;
                    else         last0_d = data;
                    read_d = 2'b00;
                    if (GAP_EN) begin
                        gap_d   = GAP_INIT;
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    hold_d = hold_q - 4'd1;
                end
            end
            ST_GAP: begin
                read_d = 2'b00;
                if (gap_q == 4'd0) state_d = ST_IDLE;
                else               gap_d   = gap_q - 4'd1;
            end
            default: begin
                read_d  = 2'b00;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            state_q        <= ST_IDLE;
            read_q         <= 2'b00;
            hold_q         <= 4'd0;
            gap_q          <= 4'd0;
            grant_q        <= 1'b0;
            rr_q           <= 1'b0;
            sample_q       <= '0;
            sample_src_q   <= 1'b0;
            sample_valid_q <= 1'b0;
            last0_q        <= '0;
            last1_q        <= '0;
        end else begin
            state_q        <= state_d;
            read_q         <= read_d;
            hold_q         <= hold_d;
            gap_q          <= gap_d;
            grant_q        <= grant_d;
            rr_q           <= rr_d;
            sample_q       <= sample_d;
            sample_src_q   <= sample_src_d;
            sample_valid_q <= sample_valid_d;
            last0_q        <= last0_d;
            last1_q        <= last1_d;
        end
    end

    assign read         = read_q;
    assign sample       = sample_q;
    assign sample_src   = sample_src_q;
    assign sample_valid = sample_valid_q;
    assign last0        = last0_q;
    assign last1        = last1_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bus_read_arbiter.sv
// tb/tb_bus_read_arbiter.sv - directed bench for bus_read_arbiter in two parameter sets
module tb_bus_read_arbiter;

    logic       clk = 1'b0;
    logic       reset_b = 1'b0;
    logic [1:0] req_a = 2'b00;
    logic [1:0] req_b = 2'b00;
    logic [7:0] cnt0 = 8'h2A;
    logic [7:0] cnt1 = 8'h51;

    wire  [7:0] bus_a;
    wire  [7:0] bus_b;
    logic [1:0] read_a, read_b;
    logic [7:0] sample_a, sample_b, last0_a, last0_b, last1_a, last1_b;
    logic       src_a, src_b, sv_a, sv_b, busy_a, busy_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign bus_a = read_a[0] ? cnt0 : (read_a[1] ? cnt1 : 8'hzz);
    assign bus_b = read_b[0] ? 8'hC3 : (read_b[1] ? 8'h3C : 8'hzz);

    bus_read_arbiter #(.DATA_W(8), .READ_CYC(1), .GAP(1)) dut_a (
        .clk(clk), .reset_b(reset_b), .req(req_a), .data(bus_a), .read(read_a),
        .sample(sample_a), .sample_src(src_a), .sample_valid(sv_a),
        .last0(last0_a), .last1(last1_a), .busy(busy_a)
    );

    bus_read_arbiter #(.DATA_W(8), .READ_CYC(3), .GAP(0)) dut_b (
        .clk(clk), .reset_b(reset_b), .req(req_b), .data(bus_b), .read(read_b),
        .sample(sample_b), .sample_src(src_b), .sample_valid(sv_b),
        .last0(last0_b), .last1(last1_b), .busy(busy_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] alt_read [9];
        logic       alt_sv   [9];
        logic [7:0] alt_val  [3];
        logic       alt_src  [3];
        int         k;
        logic [1:0] b_read   [9];
        logic       b_sv     [9];

        alt_read = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
        alt_sv   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        alt_val  = '{8'h51, 8'h2B, 8'h52};
        alt_src  = '{1'b1, 1'b0, 1'b1};
        b_read   = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00};
        b_sv     = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        // reset held two edges with both requests high
        req_a = 2'b11;
        req_b = 2'b11;
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_read_a", read_a, 2'b00);
            check("rst_busy_a", busy_a, 1'b0);
            check("rst_sv_a", sv_a, 1'b0);
            check("rst_outs_a", {sample_a, last0_a, last1_a, 7'd0, src_a}, 32'd0);
            check("rst_read_b", read_b, 2'b00);
            check("rst_busy_b", busy_b, 1'b0);
        end

        // single source 0 read
        reset_b = 1'b1;
        req_a = 2'b01;
        req_b = 2'b00;
        step();
        check("single_read", read_a, 2'b01);
        check("single_busy", busy_a, 1'b1);
        req_a = 2'b00;
        step();
        check("single_drop", read_a, 2'b00);
        check("single_sv", sv_a, 1'b1);
        check("single_sample", sample_a, 8'h2A);
        check("single_src", src_a, 1'b0);
        check("single_last0", last0_a, 8'h2A);
        cnt0 = cnt0 + 8'd1;
        step();
        check("single_sv_end", sv_a, 1'b0);
        check("single_busy_end", busy_a, 1'b0);
        step();
        check("single_idle", read_a, 2'b00);

        // both requesting: alternation, pointer now favours source 1
        req_a = 2'b11;
        k = 0;
        for (int i = 0; i < 9; i++) begin
            if (i == 8) req_a = 2'b00;
            step();
            check($sformatf("alt_read%0d", i), read_a, alt_read[i]);
            check($sformatf("alt_sv%0d", i), sv_a, alt_sv[i]);
            if (read_a != 2'b00) check($sformatf("alt_busx%0d", i), {31'd0, ^bus_a === 1'bx}, 32'd0);
            if (alt_sv[i]) begin
                check($sformatf("alt_val%0d", k), sample_a, alt_val[k]);
                check($sformatf("alt_src%0d", k), src_a, alt_src[k]);
                if (alt_src[k]) cnt1 = cnt1 + 8'd1;
                else            cnt0 = cnt0 + 8'd1;
                k++;
            end
        end
        check("alt_last0", last0_a, 8'h2B);
        check("alt_last1", last1_a, 8'h52);

        // request moves from 0 to 1 while source 0 is being read
        req_a = 2'b01;
        step();
        check("chg_read0", read_a, 2'b01);
        req_a = 2'b10;
        step();
        check("chg_sv0", sv_a, 1'b1);
        check("chg_val0", sample_a, 8'h2C);
        check("chg_src0", src_a, 1'b0);
        step();
        check("chg_gap", read_a, 2'b00);
        step();
        check("chg_read1", read_a, 2'b10);
        req_a = 2'b00;
        step();
        check("chg_sv1", sv_a, 1'b1);
        check("chg_val1", sample_a, 8'h53);
        check("chg_src1", src_a, 1'b1);

        // three-cycle hold with no gap
        req_b = 2'b01;
        for (int i = 0; i < 9; i++) begin
            step();
            if (i == 0) req_b = 2'b11;
            if (i == 4) req_b = 2'b00;
            check($sformatf("hold_read%0d", i), read_b, b_read[i]);
            check($sformatf("hold_sv%0d", i), sv_b, b_sv[i]);
        end
        check("hold_last0", last0_b, 8'hC3);
        check("hold_last1", last1_b, 8'h3C);
        check("hold_src", src_b, 1'b1);

        // reset during second read cycle aborts the transaction
        req_b = 2'b01;
        step();
        check("abort_read1", read_b, 2'b01);
        req_b = 2'b00;
        step();
        check("abort_read2", read_b, 2'b01);
        reset_b = 1'b0;
        step();
        check("abort_read", read_b, 2'b00);
        check("abort_sv", sv_b, 1'b0);
        check("abort_last", {16'd0, last0_b, last1_b}, 32'd0);
        check("abort_busy", busy_b, 1'b0);
        check("abort_last_a", {16'd0, last0_a, last1_a}, 32'd0);
        reset_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("abort_nosv%0d", i), sv_b, 1'b0);
            check($sformatf("abort_idle%0d", i), read_b, 2'b00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bus_read_arbiter.md
BUS_READ_ARBITER -- requirements
Module: bus_read_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, shared data bus width.
REQ-002 Parameter READ_CYC, default 1, number of cycles a read strobe is held (legal 1..15).
REQ-003 Parameter GAP, default 1, extra bus-turnaround idle cycles after each read (legal 0..15).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset_b  input  1  reset, synchronous, active-low.
REQ-006 req  input  2  level request per source: bit i = "read counter i".
REQ-007 data  input  DATA_W  shared tri-stated bus, driven by the source whose read is high.
REQ-008 read  output  2  read strobes to sources 0/1; registered; at most one bit high.
REQ-009 sample  output  DATA_W  last captured bus value.
REQ-010 sample_src  output  1  source index of sample.
REQ-011 sample_valid  output  1  one-cycle pulse, sample/sample_src updated this cycle.
REQ-012 last0, last1  output  DATA_W each  most recent value captured from source 0 / source 1.
REQ-013 busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 FSM states SHALL be IDLE, READ, GAP; read SHALL be driven only from the state register (never from req combinationally).
REQ-015 IDLE: read=2'b00; if any req bit high, SHALL grant one source, set read[grant]=1, load hold counter with READ_CYC-1, go READ on the next edge.
REQ-016 Arbitration SHALL be round-robin: with both requests high, grant the source not granted last; single request granted directly; after reset, source 0 has priority.
REQ-017 READ: read[grant] SHALL stay high for exactly READ_CYC consecutive cycles; hold counter decrements each cycle.
REQ-018 On the final READ cycle (counter=0), data SHALL be captured on that rising edge into sample, last<grant>, sample_src=grant; sample_valid=1 in the following cycle only; read drops to 0 on the same edge.
REQ-019 After capture: GAP>0 -> GAP state for exactly GAP cycles with read=0, then IDLE; GAP=0 -> IDLE directly.
REQ-020 Bus SHALL never see two read bits high in the same cycle, and SHALL always see at least 1 cycle (IDLE) plus GAP cycles with read=00 between consecutive reads.
REQ-021 req is sampled only in IDLE; req changes during READ/GAP SHALL NOT alter the active transaction; a request dropped during READ still completes its capture.
REQ-022 A source holding req high SHALL be re-served each round; with both high, reads alternate 0,1,0,1.
REQ-023 Latency: req high in IDLE at edge k -> read high after edge k -> sample_valid high after edge k+READ_CYC.
REQ-024 Throughput per read: READ_CYC + GAP + 1 cycles.
REQ-025 Captured value SHALL be taken verbatim (X/Z propagate in simulation; no filtering).

Reset
REQ-026 reset_b=0 at a rising edge SHALL, on that edge: state=IDLE, read=00, sample=0, sample_src=0, sample_valid=0, last0=0, last1=0, busy=0, round-robin pointer to "source 0 next".
REQ-027 Reset asserted mid-READ SHALL abort the transaction: read=00 after that edge, no sample_valid, last0/last1 cleared.
REQ-028 reset_b is ignored between edges (synchronous); first grant possible in the cycle after reset_b is sampled high.

Verification
REQ-029 Reset: hold reset_b=0 for 2 edges with req=11 -> read=00, all outputs 0, busy=0 throughout.
REQ-030 Single source: READ_CYC=1, GAP=1, source 0 model drives 8'h2A when read[0]=1, req=01 for one IDLE cycle -> read[0] high 1 cycle, sample=8'h2A, sample_src=0, sample_valid 1 cycle, last0=8'h2A, busy low after 3 cycles.
REQ-031 Contention-free alternation: two enabled counter models on shared bus, req=11 constant -> read sequence 01,00,00,10,00,00,... ; never 11; data never X while read!=00; last0/last1 track their counters.
REQ-032 Hold length: READ_CYC=3, GAP=0 -> read[i] high exactly 3 cycles, capture on 3rd, next read after exactly 1 idle cycle.
REQ-033 Abort: reset_b=0 during 2nd cycle of a READ_CYC=3 read -> read=00 next edge, sample_valid never pulses, last0=last1=0.
REQ-034 Mid-transaction req change: req 01 -> 10 during READ -> source 0 capture completes, source 1 granted at next IDLE.
